// File: rtl/systolic_drain_pkg.sv
// systolic_drain_pkg: widths, default depth and the lane clamp helper for the drain
`include "defs.sv"
package systolic_drain_pkg;
    localparam int C_WIDTH     = `C_WIDTH;
    localparam int DRAIN_DEPTH = `DRAIN_DEPTH;
    function automatic logic [C_WIDTH-1:0] relu(input logic [C_WIDTH-1:0] v);
        return v[C_WIDTH-1] ? '0 : v;
    endfunction
endpackage

// File: rtl/defs.sv
// defs: shared project-wide width and depth defaults
`ifndef DEFS_SV
`define DEFS_SV
`ifndef C_WIDTH
`define C_WIDTH 16
`endif
`ifndef DRAIN_DEPTH
`define DRAIN_DEPTH 8
`endif
`endif

// File: rtl/drain_fifo.sv
// drain_fifo: synchronous show-ahead FIFO; pointers carry one wrap bit for full/empty
module drain_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;
    assign empty   = wr_q == rd_q;
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
    assign rd_d    = do_pop ? rd_q + (AW+1)'(1) : rd_q;
    assign count   = wr_q - rd_q;
    assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];
    // storage is not reset; the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end
    // pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: deskews the array's bottom psum drain into aligned rows and queues them (optional SYSTOLIC_DRAIN_RELU_EN clamps negative lanes)
module systolic_drain
    import systolic_drain_pkg::*;
#(
    parameter int N     = 2,
    parameter int DEPTH = DRAIN_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [N-1:0][C_WIDTH-1:0]    psum_in,
    output logic [N-1:0][C_WIDTH-1:0]    out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow
);
    typedef logic [N-1:0][C_WIDTH-1:0] row_t;
    row_t aligned, wr_row;
    logic row_valid, full, empty, pop, ovf_q, ovf_d;
    if (N > 1) begin : g_vld
        logic [N-2:0] vld_q;
        // in_valid follows lane 0 through N-1 stages so it marks the aligned row
        always_ff @(posedge clk) begin
            if (rst) vld_q <= '0;
            else begin
                vld_q[0] <= in_valid;
                for (int k = 1; k < N-1; k++) vld_q[k] <= vld_q[k-1];
            end
        end
        assign row_valid = vld_q[N-2];
    end else begin : g_novld
        assign row_valid = in_valid;
    end
    for (genvar j = 0; j < N; j++) begin : g_lane
        localparam int S = N-1-j;
        if (S == 0) begin : g_pass
            assign aligned[j] = psum_in[j];
        end else begin : g_dly
            logic [C_WIDTH-1:0] sh_q [S];
            // lane j arrives j cycles late, so it needs N-1-j stages to line up
            always_ff @(posedge clk) begin
                if (rst) sh_q <= '{default: '0};
                else begin
                    sh_q[0] <= psum_in[j];
                    for (int k = 1; k < S; k++) sh_q[k] <= sh_q[k-1];
                end
            end
            assign aligned[j] = sh_q[S-1];
        end
    end
    // optional clamp sits between deskew and FIFO write, adding no latency
    always_comb begin
        wr_row = aligned;
`ifdef SYSTOLIC_DRAIN_RELU_EN
        for (int j = 0; j < N; j++) wr_row[j] = relu(aligned[j]);
`endif
    end
    assign pop       = out_valid & out_ready;
    assign out_valid = ~empty;
    assign overflow  = ovf_q;
    // a row is lost only when full with no pop freeing a slot in the same cycle
    assign ovf_d = ovf_q | (row_valid & full & ~pop);
    // sticky overflow flag, cleared only by reset
    always_ff @(posedge clk) begin
        ovf_q <= rst ? 1'b0 : ovf_d;
    end
    drain_fifo #(.WIDTH(N*C_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (row_valid),
        .pop   (pop),
        .din   (wr_row),
        .dout  (out_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );
endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: directed and scoreboard checks of the drain deskew, FIFO and overflow
module tb_systolic_drain;
    localparam int N = 4, DEPTH = 4, CW = 16;
    typedef logic [N-1:0][CW-1:0] row_t;
    logic clk = 1'b0, rst, in_valid, out_valid, out_ready, overflow;
    row_t psum_in, out_data;
    logic [2:0] count;
    row_t hist [N];
    int n_cmp = 0, n_err = 0;

    systolic_drain #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .psum_in   (psum_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic row_t mk(input logic [15:0] a, b, c, d);
        row_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    function automatic row_t rowk(input int base, input int k);
        return mk(16'(base + k*100), 16'(base + k*100 + 1), 16'(base + k*100 + 2), 16'(base + k*100 + 3));
    endfunction

    function automatic row_t exp_of(input row_t r);
        row_t e = r;
`ifdef SYSTOLIC_DRAIN_RELU_EN
        for (int j = 0; j < N; j++) if (r[j][CW-1]) e[j] = '0;
`endif
        return e;
    endfunction

    // one cycle: row r starts this cycle (lane j of it is driven j cycles later)
    task automatic cyc(input logic v, input row_t r);
        for (int j = N-1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = r;
        in_valid = v;
        for (int j = 0; j < N; j++) psum_in[j] = hist[j][j];
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input string tag, input row_t r);
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            chk({tag, "_vld"}, 64'(out_valid), 64'(c == 4));
            if (c == 4) chk({tag, "_data"}, out_data, exp_of(r));
            cyc(c == 0, c == 0 ? r : '0);
        end
        chk({tag, "_cnt"}, 64'(count), 64'(0));
    endtask

    initial begin
        row_t sb [$];
        row_t r;
        int sent, cyc_n;
        logic inj;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; psum_in = '0;
        for (int j = 0; j < N; j++) hist[j] = '0;
        cyc(0, '0);
        cyc(0, '0);
        rst = 1'b0;
        chk("rst_vld", 64'(out_valid), 64'(0));
        chk("rst_cnt", 64'(count), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_data", out_data, 64'(0));

        run_single("single", mk(10, 11, 12, 13));

        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) cyc(1, rowk(0, k));
        for (int k = 0; k < 3; k++) cyc(0, '0);
        chk("fill_cnt", 64'(count), 64'(4));
        chk("fill_ovf", 64'(overflow), 64'(1));
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("fill_vld", 64'(out_valid), 64'(1));
            chk("fill_data", out_data, exp_of(rowk(0, k)));
            cyc(0, '0);
        end
        chk("fill_empty", 64'(out_valid), 64'(0));
        chk("fill_cnt0", 64'(count), 64'(0));
        chk("fill_sticky", 64'(overflow), 64'(1));

        out_ready = 1'b0;
        cyc(1, rowk(1000, 0));
        cyc(1, rowk(1000, 1));
        cyc(0, '0);
        cyc(0, '0);
        cyc(1, rowk(1000, 2));
        chk("mid_cnt", 64'(count), 64'(2));
        rst = 1'b1;
        cyc(0, '0);
        rst = 1'b0;
        chk("mid_rst_vld", 64'(out_valid), 64'(0));
        chk("mid_rst_cnt", 64'(count), 64'(0));
        chk("mid_rst_ovf", 64'(overflow), 64'(0));
        chk("mid_rst_data", out_data, 64'(0));
        for (int k = 0; k < 4; k++) cyc(0, '0);
        chk("mid_flushed_cnt", 64'(count), 64'(0));
        chk("mid_flushed_vld", 64'(out_valid), 64'(0));
        run_single("post_rst", mk(21, 22, 23, 24));

        for (int c = 0; c < 8; c++) begin
            out_ready = (c == 7);
            if (c == 7) chk("fullpop_pre_cnt", 64'(count), 64'(4));
            cyc(c < 5, c < 5 ? rowk(2000, c) : '0);
        end
        chk("fullpop_cnt", 64'(count), 64'(4));
        chk("fullpop_ovf", 64'(overflow), 64'(0));
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            chk("fullpop_vld", 64'(out_valid), 64'(1));
            chk("fullpop_data", out_data, exp_of(rowk(2000, k)));
            cyc(0, '0);
        end
        chk("fullpop_empty", 64'(out_valid), 64'(0));

`ifdef SYSTOLIC_DRAIN_RELU_EN
        run_single("relu", mk(7, 7, 16'hFFFB, 7));
        chk("relu_lane2_const", exp_of(mk(7, 7, 16'hFFFB, 7)), mk(7, 7, 16'h0000, 7));
`else
        run_single("relu", mk(7, 7, 16'hFFFB, 7));
        chk("relu_lane2_const", exp_of(mk(7, 7, 16'hFFFB, 7)), mk(7, 7, 16'hFFFB, 7));
`endif

        sent = 0;
        cyc_n = 0;
        while ((sent < 200 || sb.size() != 0) && cyc_n < 5000) begin
            out_ready = 1'($urandom_range(0, 1));
            inj = (sent < 200) && (sb.size() < DEPTH) && ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("rnd_spurious", 64'(1), 64'(0));
                else chk("rnd_data", out_data, exp_of(sb.pop_front()));
            end
            chk("rnd_cnt_max", 64'(count <= 3'd4), 64'(1));
            for (int j = 0; j < N; j++) r[j] = 16'($urandom);
            if (inj) begin
                sb.push_back(r);
                sent++;
            end
            cyc(inj, r);
            cyc_n++;
        end
        chk("rnd_done", 64'(cyc_n < 5000), 64'(1));
        chk("rnd_ovf", 64'(overflow), 64'(0));
        chk("rnd_end_cnt", 64'(count), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
